// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the packet-bus generator/arbiter.
// Helpers are sized for the largest supported configuration; callers cast down.
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, DECODE, SEND, DONE} state_t;

    localparam int MAX_DRVRS = 16;
    localparam int MAX_PKT_W = 256;
    localparam int MAX_ID_W  = 32;

    // Destination ID sits in the top id_w bits of a pkt_w-bit packet.
    function automatic logic [MAX_ID_W-1:0] id_field(input logic [MAX_PKT_W-1:0] pkt,
                                                     input int pkt_w,
                                                     input int id_w);
        logic [MAX_PKT_W-1:0] sh;
        sh = pkt >> (pkt_w - id_w);
        return sh[MAX_ID_W-1:0];
    endfunction

    function automatic logic [MAX_DRVRS-1:0] bcast_mask(input logic [3:0] src);
        return ~(MAX_DRVRS'(1) << src);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) when mode=0, rotating
// priority starting at ptr when mode=1. One-hot grant plus binary index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] gidx
);

    always_comb begin
        int start;
        int k;
        logic [IDX_W-1:0] idx;
        grant = '0;
        gidx  = '0;
        start = mode ? int'(ptr) : 0;
        idx   = '0;
        // Walk from farthest to nearest so the nearest requester is written last.
        for (int i = N - 1; i >= 0; i--) begin
            k = start + i;
            if (k >= N) k = k - N;
            idx = IDX_W'(k);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

endmodule

// File: rtl/bs_gnrtr_n_rbtr_bp.sv
// Shared packet bus: grant one terminal, pop its head, push to dest or broadcast.
// Drops invalid/self-addressed packets and packets blocked by full[] too long.
module bs_gnrtr_n_rbtr_bp
    import bus_arb_pkg::*;
#(
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 32,
    parameter int              ID_W      = 8,
    parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
    parameter int              TIMEOUT   = 16,
    parameter int              CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DRVRS-1:0]         pndng,
    input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
    input  logic [DRVRS-1:0]         full,
    input  logic                     arb_mode,
    output logic [DRVRS-1:0]         pop,
    output logic [DRVRS-1:0]         push,
    output logic [PCKG_SZ-1:0]       D_push,
    output logic                     busy,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int IDX_W  = $clog2(DRVRS);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [PCKG_SZ-1:0]  pkt;
    logic [IDX_W-1:0]    src;
    logic [IDX_W-1:0]    rr_ptr;
    logic [DRVRS-1:0]    targets;
    logic [WCNT_W-1:0]   wcnt;

    logic [DRVRS-1:0]    grant;
    logic [IDX_W-1:0]    gidx;
    logic [PCKG_SZ-1:0]  win_pkt;
    logic [ID_W-1:0]     dest;
    logic [31:0]         dest32;
    logic [31:0]         src32;
    logic [DRVRS-1:0]    dec_targets;
    logic                dec_ok;
    logic                blocked;
    logic [IDX_W-1:0]    next_ptr;
    logic [CNT_W-1:0]    drop_inc;

    rr_arbiter #(
        .N     (DRVRS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (pndng),
        .ptr   (rr_ptr),
        .mode  (arb_mode),
        .grant (grant),
        .gidx  (gidx)
    );

    always_comb begin
        win_pkt = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (grant[i]) win_pkt = D_pop[i*PCKG_SZ +: PCKG_SZ];
        end
    end

    // Destination decode works on the latched packet, so it is stable in DECODE.
    always_comb begin
        dest        = ID_W'(id_field(MAX_PKT_W'(pkt), PCKG_SZ, ID_W));
        dest32      = 32'(dest);
        src32       = 32'(src);
        dec_targets = '0;
        dec_ok      = 1'b0;
        if (dest == BROADCAST) begin
            dec_targets = DRVRS'(bcast_mask(4'(src)));
            dec_ok      = 1'b1;
        end else if (dest32 < 32'(DRVRS) && dest32 != src32) begin
            dec_targets = DRVRS'(1) << dest;
            dec_ok      = 1'b1;
        end
    end

    assign blocked  = |(targets & full);
    assign next_ptr = (src == IDX_W'(DRVRS - 1)) ? '0 : src + 1'b1;
    assign drop_inc = (&drop_cnt) ? drop_cnt : drop_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
            rr_ptr   <= '0;
            pkt      <= '0;
            src      <= '0;
            targets  <= '0;
            wcnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pndng) begin
                        pkt   <= win_pkt;
                        src   <= gidx;
                        pop   <= grant;
                        busy  <= 1'b1;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    pop <= '0;
                    if (dec_ok) begin
                        targets <= dec_targets;
                        wcnt    <= '0;
                        state   <= SEND;
                    end else begin
                        drop_cnt <= drop_inc;
                        rr_ptr   <= next_ptr;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                SEND: begin
                    // Broadcast goes out only when every target can accept.
                    if (!blocked) begin
                        push   <= targets;
                        D_push <= pkt;
                        state  <= DONE;
                    end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
                        drop_cnt <= drop_inc;
                        rr_ptr   <= next_ptr;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    push   <= '0;
                    rr_ptr <= next_ptr;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr_bp.sv
// Randomized bench: terminal FIFOs as queues, a per-grant timeline model predicts
// pop/push/busy/drop_cnt cycle by cycle from the arbitration and routing rules.
module tb_bs_gnrtr_n_rbtr_bp;

    localparam int DRVRS   = 4;
    localparam int PCKG_SZ = 32;
    localparam int ID_W    = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;
    localparam int NCYC    = 4000;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [DRVRS-1:0]         pndng;
    logic [DRVRS*PCKG_SZ-1:0] D_pop;
    logic [DRVRS-1:0]         full;
    logic                     arb_mode;
    logic [DRVRS-1:0]         pop;
    logic [DRVRS-1:0]         push;
    logic [PCKG_SZ-1:0]       D_push;
    logic                     busy;
    logic [CNT_W-1:0]         drop_cnt;

    bs_gnrtr_n_rbtr_bp #(
        .DRVRS     (DRVRS),
        .PCKG_SZ   (PCKG_SZ),
        .ID_W      (ID_W),
        .BROADCAST (8'hFF),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .full     (full),
        .arb_mode (arb_mode),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One grant as a timeline of absolute cycle numbers.
    int               g_t, g_push, g_drop, g_end, g_src, g_b;
    logic [DRVRS-1:0] g_tgt;
    logic [PCKG_SZ-1:0] g_pkt;

    logic [PCKG_SZ-1:0] q [DRVRS][$];
    int                 m_rr;
    int                 m_drop;
    logic [PCKG_SZ-1:0] m_dpush;
    bit                 rst_done;
    int                 n_bcast, n_drop_seen;

    function automatic logic [DRVRS-1:0] model_targets(input logic [PCKG_SZ-1:0] p, input int s);
        int id;
        id = int'(p[PCKG_SZ-1 -: ID_W]);
        if (id == 255) return DRVRS'(((1 << DRVRS) - 1) & ~(1 << s));
        if (id < DRVRS && id != s) return DRVRS'(1 << id);
        return '0;
    endfunction

    function automatic int pick(input logic [DRVRS-1:0] req, input bit rr, input int ptr);
        int k;
        for (int i = 0; i < DRVRS; i++) begin
            k = rr ? (ptr + i) % DRVRS : i;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [PCKG_SZ-1:0] gen_pkt();
        logic [ID_W-1:0] id;
        int s;
        s = $urandom_range(0, 9);
        if (s < 5)       id = ID_W'($urandom_range(0, DRVRS - 1));
        else if (s < 7)  id = 8'hFF;
        else if (s == 7) id = 8'h07;
        else             id = ID_W'($urandom);
        return {id, 24'($urandom)};
    endfunction

    task automatic clear_grant(input int free_at);
        g_t = -100; g_push = -1; g_drop = -1; g_end = free_at;
        g_src = 0; g_b = 0; g_tgt = '0; g_pkt = '0;
    endtask

    initial begin
        int bs[10] = '{0, 0, 0, 0, 1, 2, 5, TIMEOUT - 1, TIMEOUT, TIMEOUT + 3};
        logic [DRVRS-1:0] exp_pop, exp_push;
        int w;

        reset = 1'b0; pndng = '0; full = '0; D_pop = '0; arb_mode = 1'b0;
        clear_grant(0);
        m_rr = 0; m_drop = 0; m_dpush = '0; rst_done = 0;
        n_bcast = 0; n_drop_seen = 0;

        repeat (3) @(negedge clk);
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_dpush", D_push, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == g_push) m_dpush = g_pkt;
            if (cyc == g_drop && m_drop < (1 << CNT_W) - 1) m_drop++;
            exp_pop  = (cyc == g_t + 1) ? DRVRS'(1 << g_src) : '0;
            exp_push = (cyc == g_push) ? g_tgt : '0;
            chk("pop", pop, exp_pop);
            chk("push", push, exp_push);
            chk("d_push", D_push, m_dpush);
            chk("busy", busy, (cyc > g_t && cyc < g_end) ? 1 : 0);
            chk("drop_cnt", drop_cnt, m_drop);
            if (cyc == g_push && $countones(g_tgt) > 1) n_bcast++;
            if (cyc == g_drop) n_drop_seen++;
            if (cyc == g_t + 1) void'(q[g_src].pop_front());

            reset = 1'b1;
            if (!rst_done && cyc > 1000 && cyc == g_t + 2 && g_tgt != 0 && g_b >= 3) begin
                // Reset while waiting on backpressure: packet is lost, not counted.
                reset = 1'b0;
                rst_done = 1;
                clear_grant(cyc + 1);
                m_rr = 0; m_drop = 0; m_dpush = '0;
            end

            if (reset && cyc >= g_end) begin
                for (int i = 0; i < DRVRS; i++)
                    if (q[i].size() < 3 && $urandom_range(0, 3) != 0) q[i].push_back(gen_pkt());
                arb_mode = 1'($urandom_range(0, 1));
                for (int i = 0; i < DRVRS; i++) begin
                    pndng[i] = (q[i].size() != 0);
                    D_pop[i*PCKG_SZ +: PCKG_SZ] = pndng[i] ? q[i][0] : PCKG_SZ'($urandom);
                end
                if (pndng != 0) begin
                    w = pick(pndng, arb_mode, m_rr);
                    m_rr  = (w + 1) % DRVRS;
                    g_t   = cyc;
                    g_src = w;
                    g_pkt = q[w][0];
                    g_tgt = model_targets(g_pkt, w);
                    g_b   = bs[$urandom_range(0, 9)];
                    if (g_tgt == 0) begin
                        g_push = -1; g_drop = cyc + 2; g_end = cyc + 2;
                    end else if (g_b >= TIMEOUT) begin
                        g_push = -1; g_drop = cyc + 2 + TIMEOUT; g_end = cyc + 2 + TIMEOUT;
                    end else begin
                        g_push = cyc + 3 + g_b; g_drop = -1; g_end = cyc + 4 + g_b;
                    end
                end
            end else begin
                // Inputs are ignored while busy; scramble them.
                pndng    = DRVRS'($urandom);
                arb_mode = 1'($urandom_range(0, 1));
                for (int i = 0; i < DRVRS; i++) D_pop[i*PCKG_SZ +: PCKG_SZ] = PCKG_SZ'($urandom);
            end

            if (g_tgt != 0 && cyc >= g_t + 2 && cyc < g_t + 2 + g_b)
                full = DRVRS'($urandom) | (g_tgt & (~g_tgt + 1'b1));
            else if (g_tgt != 0 && cyc >= g_t + 2)
                full = DRVRS'($urandom) & ~g_tgt;
            else
                full = DRVRS'($urandom);

            @(negedge clk);
        end

        chk("reset_injected", rst_done, 1);
        chk("bcast_seen", (n_bcast > 0) ? 1 : 0, 1);
        chk("drops_seen", (n_drop_seen > 0) ? 1 : 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bs_gnrtr_n_rbtr_bp.md
Name: bs_gnrtr_n_rbtr_bp

Overview:
Next-generation bus generator/arbiter connecting DRVRS terminal FIFOs over one shared packet bus.
- Grants one pending terminal, pops its head packet and decodes the destination ID from the packet's top ID_W bits.
- Pushes the packet to one destination, or to all other terminals on broadcast.
- New over the current generation: runtime-selectable fixed-priority or round-robin arbitration; destination backpressure via full[]; timeout-based drop; invalid-destination drop; drop counter.
- Sits between the terminal FIFOs and the bus interface used by the existing bus-controller environment.

Parameters:
DRVRS, 4, number of terminals (2..16)
PCKG_SZ, 32, packet width in bits
ID_W, 8, destination-ID field width; field is pkt[PCKG_SZ-1 -: ID_W]
BROADCAST, 8'hFF, destination ID meaning all terminals except source
TIMEOUT, 16, max cycles waiting on backpressure before drop
CNT_W, 16, drop counter width

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-low reset
pndng  in  DRVRS  terminal i FIFO non-empty
D_pop  in  DRVRS x PCKG_SZ  head packet of terminal i (first-word-fall-through)
full  in  DRVRS  terminal i receive FIFO cannot accept
arb_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
pop  out  DRVRS  one-cycle pop strobe to winning source
push  out  DRVRS  one-cycle push strobe(s) to destination(s)
D_push  out  PCKG_SZ  packet broadcast on bus, valid while any push bit is high
busy  out  1  high whenever state != IDLE
drop_cnt  out  CNT_W  saturating count of dropped packets

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; pop, push, D_push, busy and drop_cnt = 0; rr_ptr = 0. An in-flight packet is discarded and not counted.
- All outputs are registered.
- IDLE: if pndng != 0, pick winner w:
  - Fixed priority: lowest set index.
  - Round-robin: first set index searching upward from rr_ptr, with wrap.
  - At the same edge: pkt <= D_pop[w]; src <= w; pop <= one-hot(w); state <= DECODE.
  - arb_mode is sampled only in IDLE.
- DECODE: pop <= 0.
  - dest = pkt ID field. Targets are computed as follows:
    - dest == BROADCAST: all terminals except src.
    - dest < DRVRS and dest != src: one-hot(dest).
    - Otherwise (invalid, or self-addressed): drop. drop_cnt += 1 saturating at all-ones; state <= IDLE.
  - Valid targets: wcnt <= 0; state <= SEND.
- SEND: wait until (targets & full) == 0, then push <= targets, D_push <= pkt, state <= DONE.
  - While blocked: wcnt increments.
  - When wcnt reaches TIMEOUT-1 while still blocked: drop (count it), state <= IDLE, push stays 0.
  - Broadcast is all-or-nothing: no partial push.
- DONE: push <= 0; D_push holds its value; rr_ptr <= (src+1) mod DRVRS; state <= IDLE.
  - rr_ptr is updated for every completed or dropped grant.
- Timing: unblocked transfer has pop high in cycle N+1 and push high in cycle N+3 (N = IDLE cycle seeing pndng). Minimum 4 cycles per packet; next pop at earliest in cycle N+5.
- pndng changes while busy are ignored.
- Simultaneous pndng on all terminals: exactly one pop per grant, never two bits set.
- pop and push are never high in the same cycle.
- full is evaluated each SEND cycle. Deassertion releases the push on the following edge.

Decomposition:
- Package bus_arb_pkg: state enum {IDLE, DECODE, SEND, DONE}; function extracting the ID field; function building broadcast mask (all ones except src).
- Sub-module rr_arbiter (combinational): inputs req, ptr, mode; outputs grant one-hot and grant index. Reused by future multi-bus versions.

Test Plan:
- Reset mid-SEND: assert reset in SEND cycle → next cycle push=0, pop=0, busy=0, drop_cnt=0; later traffic proceeds normally.
- Point-to-point: DRVRS=4, terminal 1 pndng, D_pop[1]=32'h02_00ABCD → pop=4'b0010 one cycle; two cycles later push=4'b0100 with D_push=32'h02_00ABCD.
- Broadcast: terminal 2 sends 32'hFF_000001 with full=0 → push=4'b1011 in a single cycle.
- Arbitration: pndng=4'b1111 held, arb_mode=1 → pop order 0,1,2,3,0. Same with arb_mode=0 → pop always 4'b0001.
- Drops:
  - Terminal 0 sends ID 8'h07 (invalid) → no push, drop_cnt 0→1.
  - Terminal 3 sends ID 8'h03 (self) → drop_cnt 1→2.
- Backpressure: full[2]=1 for 5 cycles on dest 2 → push delayed exactly 5 cycles. full[2] held for TIMEOUT cycles → no push, drop_cnt increments, busy falls.
